instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Sequential front end that feeds the combinational control unit. It fetches opcode bytes from program memory and holds the current opcode on `inst` for decode. It reads the control unit's `genConst`/`loadAddr` decode outputs back to fetch trailing operand bytes (an 8-bit constant and/or a 16-bit address), then issues a one-cycle execute strobe. Sits between program memory and the control unit / datapath.

## Interface
- `ADDR_W`, 16, program-counter and memory address width
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `memAddr`  out  ADDR_W  program memory byte address (= PC)
- `memRdEn`  out  1  read request; held with `memAddr` stable until accepted
- `memData`  in  8  read data, valid when `memValid`
- `memValid`  in  1  read accepted/data valid; ignored unless `memRdEn`
- `stall`  in  1  blocks start of the next opcode fetch
- `inst`  out  8  instruction register, to control unit
- `genConst`  in  1  from control unit: opcode carries a constant byte
- `loadAddr`  in  1  from control unit: opcode carries a 16-bit address
- `constByte`  out  8  fetched constant operand
- `operandAddr`  out  16  fetched address operand, little-endian assembled
- `execEn`  out  1  one-cycle execute strobe; datapath gates register enables with it

## Operation
- Registers: PC, IR (`inst`), `constByte`, `operandAddr`, latched `needConst`/`needAddr`, FSM state.
- States: OP (fetch opcode), DEC (sample decode), CONST, ALO, AHI (operand fetches), EXEC.
- OP: `memRdEn`=!stall. On `memRdEn & memValid`: IR<=memData, PC<=PC+1, go DEC.
- DEC: `memRdEn`=0. Latch `needConst`<=genConst, `needAddr`<=loadAddr. Next: CONST if genConst, else ALO if loadAddr, else EXEC.
- CONST: `memRdEn`=1. On `memValid`: constByte<=memData, PC+=1. Next: ALO if needAddr, else EXEC.
- ALO: on `memValid`: operandAddr[7:0]<=memData, PC+=1, go AHI.
- AHI: on `memValid`: operandAddr[15:8]<=memData, PC+=1, go EXEC.
- EXEC: `execEn`=1 for exactly this cycle. IR, constByte, and operandAddr are stable. Go OP.
- Operand order when both flags are set: constant, then address low, then address high.
- IR retains the last opcode outside OP. Operand registers keep stale values when not refetched.
- PC arithmetic is modulo 2^ADDR_W. Incrementing from all-ones wraps to 0. No operand-fetch special case at wrap.
- `stall` applies only in OP before the request is issued. Once `memRdEn` is high in any fetch state, the request stays up until `memValid`, regardless of `stall`.
- `memValid` with `memRdEn`=0 is ignored with no state change.

## Timing
- Reset values (async, immediate):
  - state=OP, PC=RESET_PC, IR=8'h00 (NOP), constByte=0, operandAddr=0
  - execEn=0
  - memRdEn is combinational from state, so it equals !stall right after reset.
- Reset mid-operation aborts any outstanding request. Memory shares `rst_n` and must drop the pending read.
- Zero-wait memory (`memValid` same cycle as `memRdEn`):
  - plain opcode: 3 cycles (OP, DEC, EXEC)
  - +1 cycle with constant, +2 with address, +3 with both
- Each memory wait cycle adds one cycle in the corresponding fetch state.
- `genConst`/`loadAddr` are sampled only in DEC, one cycle after IR loads. Control-unit decode must settle within one cycle.
- `memAddr` = PC at all times. It changes only on the edge that accepts a byte.

## Test plan
- Reset: assert `rst_n`=0 mid-AHI -> immediately execEn=0, inst=8'h00, memAddr=RESET_PC; after release, first request at memAddr=0.
- Plain op: memory byte 0=8'b00001_011, zero-wait, genConst=loadAddr=0 -> execEn high on cycle 3 with inst=8'h0B, next request at memAddr=1.
- Constant op: bytes 8'hC1, 8'h5A with genConst=1 -> EXEC on cycle 4, constByte=8'h5A, next memAddr=2.
- Both operands: bytes 8'hE0, 8'h11, 8'h34, 8'h12 with genConst=loadAddr=1 -> EXEC on cycle 6, constByte=8'h11, operandAddr=16'h1234, next memAddr=4.
- Wait states and stall:
  - memValid delayed 2 cycles on each byte of the constant op -> EXEC delayed exactly 4 cycles, memAddr held stable while waiting.
  - stall=1 in OP -> memRdEn=0, no PC change.
  - stall raised after the request is up -> request completes.
- Wrap: RESET_PC=16'hFFFF, 2-byte constant op -> opcode read at FFFF, constant read at 0000, next opcode at 0001.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential front end between program memory and the
// control unit. Fetches an opcode into the instruction register, samples the
// control unit's decode flags, fetches any trailing constant / address bytes,
// then raises a one-cycle execute strobe.
module instruction_fetch #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRdEn,
    input  logic [7:0]        memData,
    input  logic              memValid,
    input  logic              stall,
    output logic [7:0]        inst,
    input  logic              genConst,
    input  logic              loadAddr,
    output logic [7:0]        constByte,
    output logic [15:0]       operandAddr,
    output logic              execEn
);

    typedef enum logic [2:0] {
        S_OP    = 3'd0,
        S_DEC   = 3'd1,
        S_CONST = 3'd2,
        S_ALO   = 3'd3,
        S_AHI   = 3'd4,
        S_EXEC  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        const_q, const_d;
    logic [15:0]       addr_q, addr_d;
    logic              need_const_q, need_const_d;
    logic              need_addr_q, need_addr_d;
    // Remembers that the opcode request went out, so a later stall cannot
    // withdraw it before memory accepts it.
    logic              req_q, req_d;
    logic              accept;

    // A byte is consumed only when we are actually requesting one.
    assign accept = memRdEn & memValid;

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_OP;
            pc_q         <= RESET_PC;
            ir_q         <= 8'h00;
            const_q      <= 8'h00;
            addr_q       <= 16'h0000;
            need_const_q <= 1'b0;
            need_addr_q  <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            const_q      <= const_d;
            addr_q       <= addr_d;
            need_const_q <= need_const_d;
            need_addr_q  <= need_addr_d;
            req_q        <= req_d;
        end
    end

    // Next-state and register-update logic; every accepted byte bumps the PC.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        const_d      = const_q;
        addr_d       = addr_q;
        need_const_d = need_const_q;
        need_addr_d  = need_addr_q;
        req_d        = req_q;
        unique case (state_q)
            S_OP: begin
                if (accept) begin
                    ir_d    = memData;
                    pc_d    = pc_q + PC_ONE;
                    req_d   = 1'b0;
                    state_d = S_DEC;
                end else begin
                    req_d   = memRdEn;
                end
            end
            S_DEC: begin
                need_const_d = genConst;
                need_addr_d  = loadAddr;
                if (genConst)      state_d = S_CONST;
                else if (loadAddr) state_d = S_ALO;
                else               state_d = S_EXEC;
            end
            S_CONST: begin
                if (accept) begin
                    const_d = memData;
                    pc_d    = pc_q + PC_ONE;
                    state_d = need_addr_q ? S_ALO : S_EXEC;
                end
            end
            S_ALO: begin
                if (accept) begin
                    addr_d[7:0] = memData;
                    pc_d        = pc_q + PC_ONE;
                    state_d     = S_AHI;
                end
            end
            S_AHI: begin
                if (accept) begin
                    addr_d[15:8] = memData;
                    pc_d         = pc_q + PC_ONE;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_OP;
            end
            default: begin
                state_d = S_OP;
            end
        endcase
    end

    // Outputs: read request per fetch state, execute strobe only in EXEC.
    always_comb begin
        memRdEn = 1'b0;
        execEn  = 1'b0;
        unique case (state_q)
            S_OP:                   memRdEn = ~stall | req_q;
            S_CONST, S_ALO, S_AHI:  memRdEn = 1'b1;
            S_EXEC:                 execEn  = 1'b1;
            default: begin
                memRdEn = 1'b0;
                execEn  = 1'b0;
            end
        endcase
    end

    assign memAddr     = pc_q;
    assign inst        = ir_q;
    assign constByte   = const_q;
    assign operandAddr = addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a transaction-level model (program bytes,
// PC, expected operands and the cycle-count formula) checks the fetch unit
// under directed and random wait states, stalls and decode flags.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0)
    logic        rst_n, stall, memValid, genConst, loadAddr;
    logic [7:0]  memData;
    logic [15:0] memAddr;
    logic        memRdEn, execEn;
    logic [7:0]  inst, constByte;
    logic [15:0] operandAddr;

    // Wrap instance (RESET_PC = FFFF)
    logic        rst2_n, stall2, memValid2, genConst2, loadAddr2;
    logic [7:0]  memData2;
    logic [15:0] memAddr2;
    logic        memRdEn2, execEn2;
    logic [7:0]  inst2, constByte2;
    logic [15:0] operandAddr2;

    instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .memAddr(memAddr), .memRdEn(memRdEn),
        .memData(memData), .memValid(memValid), .stall(stall), .inst(inst),
        .genConst(genConst), .loadAddr(loadAddr), .constByte(constByte),
        .operandAddr(operandAddr), .execEn(execEn)
    );

    instruction_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst_n(rst2_n), .memAddr(memAddr2), .memRdEn(memRdEn2),
        .memData(memData2), .memValid(memValid2), .stall(stall2), .inst(inst2),
        .genConst(genConst2), .loadAddr(loadAddr2), .constByte(constByte2),
        .operandAddr(operandAddr2), .execEn(execEn2)
    );

    // Reference model state
    logic [7:0]  mem [0:1023];
    logic [15:0] m_pc, m_addr;
    logic [7:0]  m_ir, m_const;
    int          k, need, cyc, blocked, wsum, rem;
    bit          pending, dec_done;
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic reset_model();
        m_pc = 16'h0000; m_ir = 8'h00; m_const = 8'h00; m_addr = 16'h0000;
        k = 0; need = 99; cyc = 0; blocked = 0; wsum = 0; rem = 0;
        pending = 1'b0; dec_done = 1'b0;
    endtask

    // Runs one instruction cycle by cycle. wfix<0 selects random waits and
    // random stall; otherwise every byte waits wfix cycles, stall is held for
    // spre cycles before the opcode request and equals sdur while a request
    // is outstanding. stop_k>0 returns once that many bytes were accepted.
    task automatic run_instr(input int lit, input int wfix, input int spre,
                             input bit sdur, input int stop_k, input string name);
        int   guard = 0;
        int   pre = 0;
        int   j;
        bit   done = 1'b0;
        bit   exp_exec, exp_rd, op_acc;
        logic [7:0] b;
        while (!done && guard < 80 && !(stop_k > 0 && k == stop_k)) begin
            guard++;
            if (wfix < 0)
                stall = ($urandom_range(0, 3) == 0);
            else if (k == 0 && !pending && pre < spre) begin
                stall = 1'b1;
                pre++;
            end else
                stall = pending ? sdur : 1'b0;
            genConst = inst[7];
            loadAddr = inst[5];
            #1;
            cyc++;
            exp_exec = (k == need) && dec_done;
            if (exp_exec)       exp_rd = 1'b0;
            else if (k == 0)    exp_rd = !stall || pending;
            else if (!dec_done) exp_rd = 1'b0;
            else                exp_rd = 1'b1;
            chk({name, ":execEn"}, execEn, exp_exec);
            chk({name, ":memRdEn"}, memRdEn, exp_rd);
            chk({name, ":memAddr"}, memAddr, m_pc);
            if (exp_exec) begin
                chk({name, ":inst"}, inst, m_ir);
                chk({name, ":constByte"}, constByte, m_const);
                chk({name, ":operandAddr"}, operandAddr, m_addr);
                chk({name, ":cycles"}, cyc, blocked + need + wsum + 2);
                if (lit > 0) chk({name, ":latency"}, cyc, lit);
                $display("%s exec inst=%02h const=%02h addr=%04h cycles=%0d next=%04h",
                         name, inst, constByte, operandAddr, cyc, memAddr);
                k = 0; need = 99; dec_done = 1'b0; cyc = 0; blocked = 0; wsum = 0;
                done = 1'b1;
            end else if (k == 0 && !exp_rd) begin
                blocked++;
            end
            // Memory responder
            op_acc   = 1'b0;
            memValid = 1'b0;
            memData  = 8'($urandom);
            if (memRdEn) begin
                if (!pending) begin
                    pending = 1'b1;
                    rem = (wfix < 0) ? int'($urandom_range(0, 2)) : wfix;
                    wsum += rem;
                end
                if (rem == 0) begin
                    memValid = 1'b1;
                    memData  = mem[memAddr[9:0]];
                    pending  = 1'b0;
                    b = mem[m_pc[9:0]];
                    if (k == 0) begin
                        m_ir   = b;
                        need   = 1 + int'(b[7]) + 2 * int'(b[5]);
                        op_acc = 1'b1;
                    end else begin
                        j = k - 1;
                        if (m_ir[7] && j == 0)          m_const      = b;
                        else if (j == (m_ir[7] ? 1 : 0)) m_addr[7:0]  = b;
                        else                             m_addr[15:8] = b;
                    end
                    m_pc++;
                    k++;
                end else begin
                    rem--;
                end
            end else begin
                memValid = ($urandom_range(0, 3) == 0);
            end
            if (!exp_exec && k >= 1 && !dec_done && !op_acc) dec_done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (stop_k == 0) chk({name, ":timeout"}, done, 1);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; memValid = 1'b0; memData = 8'h00;
        genConst = 1'b0; loadAddr = 1'b0;
        rst2_n = 1'b0; stall2 = 1'b0; memValid2 = 1'b0; memData2 = 8'h00;
        genConst2 = 1'b0; loadAddr2 = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h0B;
        mem[1] = 8'hC1; mem[2] = 8'h5A;
        mem[3] = 8'hE0; mem[4] = 8'h11; mem[5] = 8'h34; mem[6] = 8'h12;
        mem[7] = 8'h81; mem[8] = 8'h77;
        mem[9] = 8'h02;
        mem[10] = 8'hE0; mem[11] = 8'hAA; mem[12] = 8'hBB; mem[13] = 8'hCC;
        reset_model();

        // Reset state
        #1;
        chk("rst:execEn", execEn, 0);
        chk("rst:inst", inst, 8'h00);
        chk("rst:memAddr", memAddr, 16'h0000);
        chk("rst:constByte", constByte, 8'h00);
        chk("rst:operandAddr", operandAddr, 16'h0000);
        chk("rst:memRdEn", memRdEn, 1);
        stall = 1'b1;
        #1;
        chk("rst:memRdEnStall", memRdEn, 0);
        stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed: plain, constant, both operands, wait states, stall
        run_instr(3, 0, 0, 1'b0, 0, "plain");
        run_instr(4, 0, 0, 1'b0, 0, "const");
        run_instr(6, 0, 0, 1'b0, 0, "both");
        run_instr(8, 2, 0, 1'b0, 0, "wait");
        run_instr(8, 2, 3, 1'b1, 0, "stall");

        // Reset in the middle of the address-high fetch
        run_instr(-1, 0, 0, 1'b0, 3, "rstAHI");
        rst_n = 1'b0;
        memValid = 1'b0;
        stall = 1'b0;
        #1;
        chk("rstAHI:execEn", execEn, 0);
        chk("rstAHI:inst", inst, 8'h00);
        chk("rstAHI:memAddr", memAddr, 16'h0000);
        chk("rstAHI:operandAddr", operandAddr, 16'h0000);
        $display("rstAHI reset asserted memAddr=%04h inst=%02h", memAddr, inst);
        reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random program from address 0
        for (int n = 0; n < 60; n++) run_instr(-1, -1, 0, 1'b0, 0, "rand");

        // PC wrap on the second instance
        rst2_n = 1'b1;
        #1;
        chk("wrap:opAddr", memAddr2, 16'hFFFF);
        chk("wrap:opRd", memRdEn2, 1);
        memValid2 = 1'b1; memData2 = 8'h85;
        @(posedge clk); #1;
        chk("wrap:decAddr", memAddr2, 16'h0000);
        chk("wrap:decRd", memRdEn2, 0);
        chk("wrap:inst", inst2, 8'h85);
        memValid2 = 1'b0;
        genConst2 = inst2[7];
        loadAddr2 = inst2[5];
        @(posedge clk); #1;
        chk("wrap:constRd", memRdEn2, 1);
        chk("wrap:constAddr", memAddr2, 16'h0000);
        memValid2 = 1'b1; memData2 = 8'h3C;
        @(posedge clk); #1;
        memValid2 = 1'b0;
        chk("wrap:execEn", execEn2, 1);
        chk("wrap:constByte", constByte2, 8'h3C);
        chk("wrap:execAddr", memAddr2, 16'h0001);
        $display("wrap exec inst=%02h const=%02h next=%04h", inst2, constByte2, memAddr2);
        @(posedge clk); #1;
        chk("wrap:nextRd", memRdEn2, 1);
        chk("wrap:nextAddr", memAddr2, 16'h0001);
        chk("wrap:nextExec", execEn2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
